// File: rtl/npn_eval_seq.sv
// NPN-transformed truth-table scan of an external 4-input function unit: 16 operand loads, 1-cycle capture pipeline.
// Optional compare port set enabled by NPN_EVAL_CMP_EN (adds expect_tt input and match output).
module npn_eval_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  neg_mask,
  input  logic [7:0]  perm,
  input  logic        out_neg,
  output logic [3:0]  fu_x,
  input  logic        fu_y,
`ifdef NPN_EVAL_CMP_EN
  input  logic [15:0] expect_tt,
  output logic        match,
`endif
  output logic        busy,
  output logic        done,
  output logic [15:0] truth,
  output logic [4:0]  ones
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [3:0]  neg_q, neg_d;
  logic [7:0]  perm_q, perm_d;
  logic        oneg_q, oneg_d;
  logic [3:0]  fu_x_q, fu_x_d;
  logic [15:0] truth_q, truth_d;
  logic [4:0]  ones_q, ones_d;
  logic        done_q, done_d;

  logic        accept;
  logic        loading;
  logic        capturing;
  logic [3:0]  idx_lo;
  logic [3:0]  cap_idx;
  logic [3:0]  fx_next;
  logic [4:0]  pop;

`ifdef NPN_EVAL_CMP_EN
  logic [15:0] expect_q, expect_d;
  logic        match_q, match_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // idx reaching 16 means the final capture happens on this edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (abort) state_d = IDLE;
               else if (idx_q[4]) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SCAN);
    done = done_q;
  end

  assign accept    = (state_q == IDLE) && start;
  assign loading   = (state_q == SCAN) && !abort && !idx_q[4];
  assign capturing = (state_q == SCAN) && !abort && (idx_q != 5'd0);
  assign idx_lo    = idx_q[3:0];
  // Wraps to 15 when idx is 16, which is exactly the last capture slot.
  assign cap_idx   = idx_q[3:0] - 4'd1;

  always_comb begin
    fx_next = 4'h0;
    for (int i = 0; i < 4; i++) begin
      fx_next[i] = idx_lo[perm_q[2*i +: 2]] ^ neg_q[i];
    end
  end

  always_comb begin
    pop = 5'd0;
    for (int i = 0; i < 16; i++) begin
      pop = pop + {4'd0, truth_q[i]};
    end
  end

  always_comb begin
    idx_d   = idx_q;
    neg_d   = neg_q;
    perm_d  = perm_q;
    oneg_d  = oneg_q;
    fu_x_d  = fu_x_q;
    truth_d = truth_q;
    ones_d  = ones_q;
    done_d  = (state_q == DONE);
    if (accept) begin
      idx_d   = 5'd0;
      neg_d   = neg_mask;
      perm_d  = perm;
      oneg_d  = out_neg;
      truth_d = 16'h0000;
    end
    if (loading) begin
      fu_x_d = fx_next;
      idx_d  = idx_q + 5'd1;
    end
    if (capturing) begin
      truth_d[cap_idx] = fu_y ^ oneg_q;
    end
    if (state_q == DONE) begin
      ones_d = pop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= 5'd0;
      neg_q   <= 4'h0;
      perm_q  <= 8'h00;
      oneg_q  <= 1'b0;
      fu_x_q  <= 4'h0;
      truth_q <= 16'h0000;
      ones_q  <= 5'd0;
      done_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      neg_q   <= neg_d;
      perm_q  <= perm_d;
      oneg_q  <= oneg_d;
      fu_x_q  <= fu_x_d;
      truth_q <= truth_d;
      ones_q  <= ones_d;
      done_q  <= done_d;
    end
  end

  assign fu_x  = fu_x_q;
  assign truth = truth_q;
  assign ones  = ones_q;

`ifdef NPN_EVAL_CMP_EN
  always_comb begin
    expect_d = expect_q;
    match_d  = match_q;
    if (accept) begin
      expect_d = expect_tt;
      match_d  = 1'b0;
    end
    if (state_q == DONE) begin
      match_d = (truth_q == expect_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expect_q <= 16'h0000;
      match_q  <= 1'b0;
    end else begin
      expect_q <= expect_d;
      match_q  <= match_d;
    end
  end

  assign match = match_q;
`endif

endmodule

// File: tb/tb_npn_eval_seq.sv
// Directed bench for npn_eval_seq with an AND(x0,x1) function unit modelled alongside.
module tb_npn_eval_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [3:0]  neg_mask;
  logic [7:0]  perm;
  logic        out_neg;
  logic [3:0]  fu_x;
  logic        fu_y;
  logic        busy;
  logic        done;
  logic [15:0] truth;
  logic [4:0]  ones;
`ifdef NPN_EVAL_CMP_EN
  logic [15:0] expect_tt;
  logic        match;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign fu_y = fu_x[0] & fu_x[1];

  npn_eval_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .neg_mask  (neg_mask),
    .perm      (perm),
    .out_neg   (out_neg),
    .fu_x      (fu_x),
    .fu_y      (fu_y),
`ifdef NPN_EVAL_CMP_EN
    .expect_tt (expect_tt),
    .match     (match),
`endif
    .busy      (busy),
    .done      (done),
    .truth     (truth),
    .ones      (ones)
  );

  typedef struct {
    logic [3:0]  neg;
    logic [7:0]  pm;
    logic        on;
    logic [15:0] tt;
    logic [4:0]  n1;
    logic [3:0]  fx;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Launch one scan and watch a fixed 31-cycle window; glitch pulses start mid-scan and in DONE.
  task automatic run_scan(input vec_t v, input bit glitch, output int lat, output int dcnt, output int bcnt);
    @(negedge clk);
    neg_mask = v.neg;
    perm     = v.pm;
    out_neg  = v.on;
`ifdef NPN_EVAL_CMP_EN
    expect_tt = v.tt;
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat  = -1;
    dcnt = 0;
    bcnt = 0;
    for (int k = 0; k <= 30; k++) begin
      if (k != 0) begin
        @(posedge clk);
        #1;
      end
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (lat < 0) lat = k;
      end
      if (glitch) begin
        if (k == 6 || k == 17) begin
          start    = 1'b1;
          neg_mask = 4'h3;
          out_neg  = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int lat, dcnt, bcnt;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    neg_mask = 4'h0;
    perm     = 8'h00;
    out_neg  = 1'b0;
`ifdef NPN_EVAL_CMP_EN
    expect_tt = 16'h0000;
`endif

    vecs[0] = '{neg: 4'h0, pm: 8'hE4, on: 1'b0, tt: 16'h8888, n1: 5'd4,  fx: 4'hF};
    vecs[1] = '{neg: 4'h3, pm: 8'hE4, on: 1'b0, tt: 16'h1111, n1: 5'd4,  fx: 4'hC};
    vecs[2] = '{neg: 4'h0, pm: 8'hE4, on: 1'b1, tt: 16'h7777, n1: 5'd12, fx: 4'hF};
    vecs[3] = '{neg: 4'h0, pm: 8'h4E, on: 1'b0, tt: 16'hF000, n1: 5'd4,  fx: 4'hF};
    vecs[4] = '{neg: 4'hA, pm: 8'hFF, on: 1'b0, tt: 16'h0000, n1: 5'd0,  fx: 4'h5};
    vecs[5] = '{neg: 4'hF, pm: 8'hE4, on: 1'b0, tt: 16'h1111, n1: 5'd4,  fx: 4'h0};
    vecs[6] = '{neg: 4'h0, pm: 8'hE6, on: 1'b0, tt: 16'hC0C0, n1: 5'd4,  fx: 4'hF};
    vecs[7] = '{neg: 4'h1, pm: 8'h00, on: 1'b1, tt: 16'hFFFF, n1: 5'd16, fx: 4'hE};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_truth", 32'(truth), 32'd0);
    chk("rst_ones",  32'(ones),  32'd0);
    chk("rst_fu_x",  32'(fu_x),  32'd0);
`ifdef NPN_EVAL_CMP_EN
    chk("rst_match", 32'(match), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rel_no_start", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_scan(vecs[i], 1'b0, lat, dcnt, bcnt);
      chk($sformatf("v%0d_latency", i), 32'(lat),   32'd18);
      chk($sformatf("v%0d_done_w", i),  32'(dcnt),  32'd1);
      chk($sformatf("v%0d_busy_w", i),  32'(bcnt),  32'd17);
      chk($sformatf("v%0d_truth", i),   32'(truth), 32'(vecs[i].tt));
      chk($sformatf("v%0d_ones", i),    32'(ones),  32'(vecs[i].n1));
      chk($sformatf("v%0d_fu_x", i),    32'(fu_x),  32'(vecs[i].fx));
`ifdef NPN_EVAL_CMP_EN
      chk($sformatf("v%0d_match", i),   32'(match), 32'd1);
`endif
    end

    // Abort on the 5th SCAN cycle; ones must keep 16 from the last table scan.
    @(negedge clk);
    neg_mask = 4'h0;
    perm     = 8'hE4;
    out_neg  = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    dcnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    chk("abort_no_done", 32'(dcnt),         32'd0);
    chk("abort_truth_hi", 32'(truth[15:4]), 32'd0);
    chk("abort_ones",     32'(ones),        32'd16);

    run_scan(vecs[0], 1'b1, lat, dcnt, bcnt);
    chk("glitch_latency", 32'(lat),   32'd18);
    chk("glitch_done_w",  32'(dcnt),  32'd1);
    chk("glitch_busy_w",  32'(bcnt),  32'd17);
    chk("glitch_truth",   32'(truth), 32'h8888);
    chk("glitch_ones",    32'(ones),  32'd4);

    // Reset asserted on the 10th SCAN cycle.
    @(negedge clk);
    neg_mask = 4'h0;
    perm     = 8'hE4;
    out_neg  = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy",  32'(busy),  32'd0);
    chk("mrst_done",  32'(done),  32'd0);
    chk("mrst_truth", 32'(truth), 32'd0);
    chk("mrst_ones",  32'(ones),  32'd0);
    chk("mrst_fu_x",  32'(fu_x),  32'd0);
`ifdef NPN_EVAL_CMP_EN
    chk("mrst_match", 32'(match), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_idle", 32'(busy), 32'd0);
    run_scan(vecs[0], 1'b0, lat, dcnt, bcnt);
    chk("mrst_rescan_lat",   32'(lat),   32'd18);
    chk("mrst_rescan_truth", 32'(truth), 32'h8888);
    chk("mrst_rescan_ones",  32'(ones),  32'd4);

`ifdef NPN_EVAL_CMP_EN
    begin
      vec_t vm;
      vm = vecs[0];
      vm.tt = 16'h8889;
      run_scan(vm, 1'b0, lat, dcnt, bcnt);
      chk("cmp_mismatch", 32'(match), 32'd0);
      chk("cmp_truth",    32'(truth), 32'h8888);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
